// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared Q-format constants, saturation helper and FIFO entry type
// Purpose: definitions shared by attn_score_stream and attn_exp_lut.
//   EXP_FRAC / X_W / EXP_W : Q1.6 exponent input and UQ3.6 score formats
//   fifo_entry_t           : one output FIFO entry {score, last, sum}
//   sat_signed()           : clamp a wide signed value into the X_W-bit range
//   credit_w()             : width needed to hold a credit count 0..depth
package attn_pkg;

  localparam int EXP_FRAC  = 6;
  localparam int X_W       = 8;
  localparam int EXP_W     = 9;
  // Widest row sum an entry can carry; the top keeps only SUM_W bits of it.
  localparam int SUM_MAX_W = 16;

  typedef logic signed [X_W-1:0] x_t;

  typedef struct packed {
    logic [EXP_W-1:0]     score;
    logic                 last;
    logic [SUM_MAX_W-1:0] sum;
  } fifo_entry_t;

  function automatic x_t sat_signed(input logic signed [63:0] v);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (X_W - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (X_W - 1));
    if (v > hi) return hi[X_W-1:0];
    if (v < lo) return lo[X_W-1:0];
    return v[X_W-1:0];
  endfunction

  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/attn_exp_lut.sv
// rtl/attn_exp_lut.sv - combinational e^x ROM, Q1.6 signed in, UQ3.6 unsigned out
// Purpose: score_o = round(64 * e^(x_i/64)) for every x_i in [-128,127].
// Ports:
//   x_i     in  X_W    exponent argument, signed Q1.6
//   score_o out EXP_W  exponential, unsigned UQ3.6
module attn_exp_lut
  import attn_pkg::*;
(
  input  x_t               x_i,
  output logic [EXP_W-1:0] score_o
);

  // Table contents are computed at elaboration with a Taylor series in Q60
  // fixed point; 40 terms leave the truncation error far below one LSB.
  function automatic logic [EXP_W-1:0] exp_q6(input int x);
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] xs;
    logic signed [127:0] rounded;
    xs   = 128'(x);
    term = 128'sd1 <<< 60;
    sum  = term;
    for (int n = 1; n < 40; n++) begin
      term = (term * xs) / 128'(64 * n);
      sum  = sum + term;
    end
    rounded = (sum <<< EXP_FRAC) + (128'sd1 <<< 59);
    rounded = rounded >>> 60;
    return rounded[EXP_W-1:0];
  endfunction

  logic [EXP_W-1:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_rom
    localparam logic [EXP_W-1:0] ENTRY = exp_q6(i - 128);
    assign rom[i] = ENTRY;
  end

  // Offset-binary index: x = -128 maps to entry 0.
  logic [X_W-1:0] idx;
  assign idx     = {~x_i[X_W-1], x_i[X_W-2:0]};
  assign score_o = rom[idx];

endmodule

// File: rtl/attn_score_stream.sv
// rtl/attn_score_stream.sv - streaming Q.K dot product, scale, e^x and row sum with credit flow control
// Purpose: accumulate N_FEAT signed Q/K products, scale and saturate to Q1.6,
//   exponentiate through attn_exp_lut and queue {score, last, running row sum}.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_valid/in_ready    Q/K pair handshake; in_ready is registered, credit based
//   in_q, in_k           signed Q0.(DATA_W-1) query/key elements
//   out_valid/out_ready  score handshake from the output FIFO head
//   out_score            e^x, UQ3.6
//   out_last             final score of a row
//   out_sum              running row sum including this score
module attn_score_stream
  import attn_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int N_FEAT      = 4,
  parameter int ROW_LEN     = 4,
  parameter int SCALE_SHIFT = 1,
  parameter int FIFO_DEPTH  = 2,
  parameter int SUM_W       = EXP_W + $clog2(ROW_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_q,
  input  logic signed [DATA_W-1:0] in_k,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W-1:0]         out_score,
  output logic                     out_last,
  output logic [SUM_W-1:0]         out_sum
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = PROD_W + $clog2(N_FEAT);
  // Scaling shift and Q.(2*(DATA_W-1)) -> Q.6 reduction folded into one floor shift.
  localparam int RED_SH = SCALE_SHIFT + 2 * (DATA_W - 1) - EXP_FRAC;
  localparam int FC_W   = $clog2(N_FEAT);
  localparam int RC_W   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CRED_W = credit_w(FIFO_DEPTH);

  logic [FC_W-1:0]         fcnt_q, fcnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CRED_W-1:0]       credit_q, credit_d;
  logic                    in_ready_q;
  logic                    s1_valid_q;
  x_t                      s1_x_q, s1_x_d;
  logic [RC_W-1:0]         rcnt_q, rcnt_d;
  logic [SUM_W-1:0]        rowsum_q, rowsum_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CRED_W-1:0]       count_q, count_d;
  fifo_entry_t             fifo_mem [FIFO_DEPTH];

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  dot;
  logic signed [ACC_W-1:0]  red;
  logic                     beat_fire, final_fire, push, pop;
  logic [EXP_W-1:0]         lut_score;
  logic                     wr_last;
  logic [SUM_W-1:0]         wr_sum;
  fifo_entry_t              wr_entry, head;

  assign prod       = in_q * in_k;
  assign dot        = acc_q + ACC_W'(prod);
  assign red        = dot >>> RED_SH;
  assign beat_fire  = in_valid & in_ready_q;
  assign final_fire = beat_fire & (fcnt_q == FC_W'(N_FEAT - 1));
  assign push       = s1_valid_q;
  assign out_valid  = (count_q != '0);
  assign pop        = out_valid & out_ready;

  attn_exp_lut u_exp (
    .x_i     (s1_x_q),
    .score_o (lut_score)
  );

  assign wr_last        = (rcnt_q == RC_W'(ROW_LEN - 1));
  assign wr_sum         = ((rcnt_q == '0) ? '0 : rowsum_q) + SUM_W'(lut_score);
  assign wr_entry.score = lut_score;
  assign wr_entry.last  = wr_last;
  assign wr_entry.sum   = SUM_MAX_W'(wr_sum);

  assign head      = fifo_mem[rd_ptr_q];
  assign out_score = out_valid ? head.score : '0;
  assign out_last  = out_valid & head.last;
  assign out_sum   = out_valid ? SUM_W'(head.sum) : '0;
  assign in_ready  = in_ready_q;

  always_comb begin
    fcnt_d   = fcnt_q;
    acc_d    = acc_q;
    s1_x_d   = s1_x_q;
    credit_d = credit_q;
    rcnt_d   = rcnt_q;
    rowsum_d = rowsum_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (beat_fire) begin
      acc_d  = (fcnt_q == '0) ? ACC_W'(prod) : dot;
      fcnt_d = final_fire ? '0 : fcnt_q + FC_W'(1);
    end
    if (final_fire) begin
      s1_x_d = sat_signed(64'(red));
    end

    // A credit is taken when a dot product completes and returned on pop,
    // so completed-but-unpopped results never exceed FIFO_DEPTH.
    if (final_fire && !pop) begin
      credit_d = credit_q - CRED_W'(1);
    end else if (pop && !final_fire) begin
      credit_d = credit_q + CRED_W'(1);
    end

    if (push) begin
      rowsum_d = wr_sum;
      rcnt_d   = wr_last ? '0 : rcnt_q + RC_W'(1);
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CRED_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CRED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt_q     <= '0;
      acc_q      <= '0;
      credit_q   <= CRED_W'(FIFO_DEPTH);
      in_ready_q <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      rcnt_q     <= '0;
      rowsum_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fcnt_q     <= fcnt_d;
      acc_q      <= acc_d;
      credit_q   <= credit_d;
      in_ready_q <= (credit_d != '0);
      s1_valid_q <= final_fire;
      s1_x_q     <= s1_x_d;
      rcnt_q     <= rcnt_d;
      rowsum_q   <= rowsum_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is not reset; the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: tb/tb_attn_score_stream.sv
// tb/tb_attn_score_stream.sv - self-checking bench for attn_score_stream
module tb_attn_score_stream;

  localparam int N_FEAT     = 4;
  localparam int ROW_LEN    = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int SUM_W      = 11;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_q;
  logic signed [7:0] in_k;
  logic              out_valid;
  logic              out_ready;
  logic [8:0]        out_score;
  logic              out_last;
  logic [SUM_W-1:0]  out_sum;

  attn_score_stream #(
    .DATA_W(8), .N_FEAT(N_FEAT), .ROW_LEN(ROW_LEN), .SCALE_SHIFT(1), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_score(out_score), .out_last(out_last), .out_sum(out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int score; int last; int sum; } exp_t;
  typedef struct { int q; int k; int nz; int score; } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  exp_t expq[$];
  exp_t pop_log[$];
  int   m_fcnt, m_dot, m_rc, m_rsum, m_credit;
  bit   hold_prev, rand_ready;
  int   h_score, h_last, h_sum;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int ref_score(input int dot);
    int x;
    x = (dot >>> 1) >>> 8;
    if (x > 127) x = 127;
    if (x < -128) x = -128;
    return $rtoi(64.0 * $exp(real'(x) / 64.0) + 0.5);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    expq.delete();
    pop_log.delete();
    m_fcnt = 0; m_dot = 0; m_rc = 0; m_rsum = 0; m_credit = FIFO_DEPTH;
    hold_prev = 1'b0;
  endtask

  task automatic step(output bit accepted);
    bit   fin, pop;
    exp_t e;
    @(negedge clk);
    chk("credit", int'(dut.credit_q), m_credit);
    chk("in_ready", int'(in_ready), (m_credit != 0) ? 1 : 0);
    if (hold_prev) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_score", int'(out_score), h_score);
      chk("hold_last", int'(out_last), h_last);
      chk("hold_sum", int'(out_sum), h_sum);
    end
    pop = out_valid && out_ready;
    accepted = in_valid && in_ready;
    fin = 1'b0;
    if (pop) begin
      if (expq.size() == 0) begin
        chk("spurious_pop", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("score", int'(out_score), e.score);
        chk("last", int'(out_last), e.last);
        chk("sum", int'(out_sum), e.sum);
      end
      pop_log.push_back('{int'(out_score), int'(out_last), int'(out_sum)});
    end
    hold_prev = out_valid && !out_ready;
    h_score = int'(out_score); h_last = int'(out_last); h_sum = int'(out_sum);
    if (accepted) begin
      m_dot = ((m_fcnt == 0) ? 0 : m_dot) + int'(in_q) * int'(in_k);
      if (m_fcnt == N_FEAT - 1) begin
        fin = 1'b1;
        m_fcnt = 0;
        e.score = ref_score(m_dot);
        e.sum = ((m_rc == 0) ? 0 : m_rsum) + e.score;
        e.last = (m_rc == ROW_LEN - 1) ? 1 : 0;
        m_rsum = e.sum;
        m_rc = (m_rc == ROW_LEN - 1) ? 0 : m_rc + 1;
        expq.push_back(e);
      end else begin
        m_fcnt++;
      end
    end
    if (fin && !pop) m_credit--;
    else if (pop && !fin) m_credit++;
    @(posedge clk); #1;
    if (rand_ready) out_ready = ($urandom_range(0, 99) < 60);
  endtask

  task automatic send_beat(input int q, input int k);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_q = 8'(q);
    in_k = 8'(k);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      step(acc);
      n++;
    end
    if (!acc) chk("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int f = 0; f < N_FEAT; f++) begin
      if (f < v.nz) send_beat(v.q, v.k);
      else send_beat(0, 0);
    end
  endtask

  task automatic wait_pops(input int n, input int bound);
    bit acc;
    int c;
    c = 0;
    while (pop_log.size() < n && c < bound) begin
      step(acc);
      c++;
    end
    chk("pop_count", pop_log.size(), n);
  endtask

  vec_t vecs[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   acc;
    int   nacc;
    vec_t v;

    vecs[0] = '{64, 64, 4, 106};
    vecs[1] = '{0, 0, 4, 64};
    vecs[2] = '{-128, -128, 4, 466};
    vecs[3] = '{127, -128, 4, 9};
    vecs[4] = '{64, -64, 4, 39};
    vecs[5] = '{127, 127, 4, 458};
    vecs[6] = '{64, 64, 1, 73};
    vecs[7] = '{-1, 1, 4, 63};
    vecs[8] = '{-128, -128, 2, 174};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_q = '0; in_k = '0;
    rand_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_score", int'(out_score), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_fcnt", int'(dut.fcnt_q), 0);
    chk("rst_rcnt", int'(dut.rcnt_q), 0);
    chk("rst_s1_valid", int'(dut.s1_valid_q), 0);

    // Latency: final beat accepted at t, out_valid at t+2.
    v = '{64, 64, 4, 106};
    send_vec(v);
    chk("lat_t1_valid", int'(out_valid), 0);
    step(acc);
    chk("lat_t2_valid", int'(out_valid), 1);
    chk("lat_score", int'(out_score), 106);
    chk("lat_last", int'(out_last), 0);
    chk("lat_sum", int'(out_sum), 106);
    out_ready = 1'b1;
    wait_pops(1, 10);

    // Table of directed vectors, streamed with out_ready held high.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_vec(vecs[i]);
      wait_pops(i + 1, 20);
      if (pop_log.size() == i + 1) chk($sformatf("tbl_score_%0d", i), pop_log[i].score, vecs[i].score);
    end

    // One all-zero row: sums 64..256, last only on the fourth.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_vec('{0, 0, 4, 64});
    wait_pops(4, 20);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) begin
        chk($sformatf("row_sum_%0d", i), pop_log[i].sum, 64 * (i + 1));
        chk($sformatf("row_last_%0d", i), pop_log[i].last, (i == 3) ? 1 : 0);
      end
    end

    // Reset after two of four features discards the partial product.
    do_reset();
    out_ready = 1'b1;
    send_beat(64, 64);
    send_beat(64, 64);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step(acc);
    chk("mid_rst_no_out", pop_log.size(), 0);
    send_vec('{64, 64, 4, 106});
    wait_pops(1, 10);
    if (pop_log.size() == 1) begin
      chk("mid_rst_score", pop_log[0].score, 106);
      chk("mid_rst_sum", pop_log[0].sum, 106);
      chk("mid_rst_last", pop_log[0].last, 0);
    end

    // Backpressure: credits run out after the second final beat.
    do_reset();
    out_ready = 1'b0;
    send_vec('{64, 64, 4, 106});
    chk("bp_ready_after1", int'(in_ready), 1);
    send_vec('{0, 0, 4, 64});
    chk("bp_stall", int'(in_ready), 0);
    in_valid = 1'b1; in_q = -8'sd128; in_k = -8'sd128;
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      step(acc);
      if (acc) nacc++;
    end
    chk("bp_no_accept", nacc, 0);
    chk("bp_head_score", int'(out_score), 106);
    out_ready = 1'b1;
    step(acc);
    chk("bp_pop_no_accept", int'(acc), 0);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_credit_after_pop", int'(dut.credit_q), 1);
    for (int f = 0; f < 3; f++) send_beat(-128, -128);
    out_ready = 1'b1;
    send_beat(-128, -128);
    chk("bp_credit_same", int'(dut.credit_q), 1);
    wait_pops(3, 20);
    if (pop_log.size() == 3) begin
      chk("bp_order0", pop_log[0].score, 106);
      chk("bp_order1", pop_log[1].score, 64);
      chk("bp_order2", pop_log[2].score, 466);
    end

    // Random valid/ready gaps against the reference model.
    do_reset();
    rand_ready = 1'b1;
    out_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      for (int f = 0; f < N_FEAT; f++) begin
        while ($urandom_range(0, 3) == 0) step(acc);
        send_beat(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      end
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && expq.size() != 0; i++) step(acc);
    chk("rand_drained", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/attn_score_stream.md
# attn_score_stream

Parametrised streaming attention-score engine for the credit-pipeline attention datapath. Consumes Q/K feature pairs over valid/ready, forms an N_FEAT-term signed dot product, scales and saturates it to Q1.6, and applies e^x through a lookup sub-module. It emits UQ3.6 scores with a per-row running sum for the downstream softmax divider, and uses credit-based flow control so it never overflows its output FIFO.

## Interface
- DATA_W, 8: Q/K element width, signed Q0.(DATA_W-1).
- N_FEAT, 4: features per dot product, ≥2.
- ROW_LEN, 4: scores per attention row, ≥1.
- SCALE_SHIFT, 1: arithmetic right shift applied to the dot product (1/√d scaling).
- FIFO_DEPTH, 2: output FIFO entries, and initial credit count, ≥1.
- EXP_W, 9 (fixed): score width, UQ3.6.
- SUM_W, EXP_W+$clog2(ROW_LEN) (derived): row-sum width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  Q/K pair valid.
- in_ready  out  1  pair accepted when in_valid & in_ready.
- in_q  in  DATA_W  query element, signed.
- in_k  in  DATA_W  key element, signed.
- out_valid  out  1  score valid.
- out_ready  in  1  score popped when out_valid & out_ready.
- out_score  out  EXP_W  e^x, UQ3.6.
- out_last  out  1  final score of a row.
- out_sum  out  SUM_W  running row sum including this score; complete when out_last=1.

## Operation
- Feature counter fcnt runs 0..N_FEAT-1 on accepted beats and wraps after N_FEAT-1.
- Product: p = in_q*in_k, signed, 2*DATA_W bits.
- Accumulation: on fcnt=0, acc loads p. Otherwise acc adds p. acc width is 2*DATA_W+$clog2(N_FEAT), so it cannot overflow.
- Final beat (fcnt=N_FEAT-1): d = acc+p. Then s = d >>> SCALE_SHIFT.
- Fraction reduction: drop the low 2*(DATA_W-1)-6 bits with an arithmetic shift (floor). Saturate to the signed 8-bit range [-128,127] to form x in Q1.6. Register x into stage S1 with s1_valid.
- Exp: attn_exp_lut maps x to round(64·e^(x/64)), 9-bit unsigned, combinationally from S1.
- FIFO write: the result is written to the FIFO the cycle after S1 loads.
- Row counter rcnt (0..ROW_LEN-1) and row-sum register live on the write side. For each entry, sum = (rcnt=0 ? 0 : rowsum) + score, and last = (rcnt=ROW_LEN-1). The entry stores {score, last, sum}. rcnt wraps after ROW_LEN-1.
- Credits: credit_cnt resets to FIFO_DEPTH.
  - It decrements when a final beat is accepted and increments on an output pop.
  - If both happen in the same cycle, it is unchanged.
- in_ready = (credit_cnt != 0), so all beats stall at zero credits. The FIFO therefore can never overflow and has no full-drop path.
- The FIFO is a circular buffer with wrapping pointers. It handles simultaneous push and pop in the same cycle, including when it is empty or full.
- Reset mid-row or mid-dot-product: the partial acc, S1, the FIFO, rcnt and the row sum are all discarded. No partial output is emitted.

## Timing
- Reset values:
  - in_ready=1 (credit_cnt=FIFO_DEPTH).
  - out_valid=0, out_score=0, out_last=0, out_sum=0.
  - fcnt=0, rcnt=0, acc=0, s1_valid=0.
- Latency: final beat accepted at cycle t → S1 valid at t+1 → out_valid=1 at t+2 when the FIFO was empty. Full throughput is one pair per cycle.
- Back-to-back dot products sustain one score per N_FEAT cycles when out_ready=1 and FIFO_DEPTH≥2.
- out_* are driven from the FIFO head and stay stable while out_valid & !out_ready.
- in_ready is a registered function of credit_cnt only. It never combinationally depends on in_valid or out_ready.

## Structure
- Shared package attn_pkg: Q-format constants (EXP_FRAC=6, X_W=8), the sat_signed function, the credit-counter width helper, and the FIFO entry struct type {score, last, sum}.
- Sub-module attn_exp_lut: 256-entry ROM, 8-bit signed in, 9-bit unsigned out, combinational.
- FIFO is inline in attn_score_stream.

## Test plan
- q=k=64 for 4 beats (defaults) → d=16384, x=32, out_score=106, out_valid 2 cycles after the last beat.
- All-zero inputs, one row of 4 dot products → four scores of 64; out_sum 64,128,192,256; out_last only on the 4th.
- q=k=-128 ×4 → x saturates to 127, score=466. q=127, k=-128 ×4 → x=-127, score=9.
- out_ready=0, FIFO_DEPTH=2, three dot products streamed → in_ready drops after the 2nd final beat and no data is lost. Release out_ready → third completes in order. Check simultaneous pop/accept leaves credit_cnt unchanged.
- Assert rst_n low for one cycle after 2 of 4 features → no output; the next 4-beat product gives the correct score and starts a fresh row (out_sum = score).
- Random valid/ready gaps, 1000 products vs. reference model → exact match; credit_cnt stays ≤ FIFO_DEPTH.
